// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus: memory port, decode handshake, redirect, status and perf counters.
// master = fetch_sequencer side, slave = surrounding pipeline / memory side.
interface fetch_sequencer_if;
  logic        start;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [7:0]  out_pc;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        busy;
  logic        done;
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;

  modport master (
    input  start, imem_instr, out_ready, redirect_valid, redirect_pc,
    output imem_addr, out_valid, out_instr, out_pc, busy, done, fetch_cnt, stall_cnt
  );

  modport slave (
    output start, imem_instr, out_ready, redirect_valid, redirect_pc,
    input  imem_addr, out_valid, out_instr, out_pc, busy, done, fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: PC sequencing, 2-entry fetch queue, redirect flush.
// Optional perf counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] PROG_END = 8'h34
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [7:0]  r_pc;
  logic [15:0] r_q_instr [2];
  logic [7:0]  r_q_pc    [2];
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_next;
  logic        w_redirect, w_start, w_issue, w_push, w_pop, w_wr_idx;
  logic        w_busy, w_done;

  assign w_redirect = bus.redirect_valid && (r_state != S_IDLE);
  assign w_start    = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE)) && !w_redirect;
  assign w_pop      = (r_cnt != 2'd0) && bus.out_ready;
  // The memory answers at the edge closing the issue cycle, so a redirect on that edge kills it.
  assign w_push     = w_issue && !w_redirect;
  assign w_wr_idx   = r_cnt[1] | (r_cnt[0] & !w_pop);
  assign w_cnt_next = (w_redirect || w_start) ? 2'd0
                    : r_cnt - {1'b0, w_pop} + {1'b0, w_push};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_redirect || w_start) begin
      w_state_next = S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_issue && (r_pc == PROG_END)) w_state_next = S_DRAIN;
        S_DRAIN: if (w_cnt_next == 2'd0) w_state_next = S_DONE;
        default: w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    w_busy  = (r_state == S_RUN) || (r_state == S_DRAIN);
    w_done  = (r_state == S_DONE);
    w_issue = (r_state == S_RUN) && (r_cnt != 2'd2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_pc <= RESET_PC & 8'hFE;
    else if (w_redirect) r_pc <= bus.redirect_pc & 8'hFE;
    else if (w_start)    r_pc <= RESET_PC & 8'hFE;
    else if (w_issue)    r_pc <= r_pc + 8'd2;
  end

  // Head always sits in slot 0; a pop shifts slot 1 down, and a same-cycle push wins over the shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else begin
      r_cnt <= w_cnt_next;
      if (!w_redirect && !w_start) begin
        if (w_pop) begin
          r_q_instr[0] <= r_q_instr[1];
          r_q_pc[0]    <= r_q_pc[1];
        end
        if (w_push) begin
          r_q_instr[w_wr_idx] <= bus.imem_instr;
          r_q_pc[w_wr_idx]    <= r_pc;
        end
      end
    end
  end

  assign bus.imem_addr = r_pc;
  assign bus.out_valid = (r_cnt != 2'd0);
  assign bus.out_instr = r_q_instr[0];
  assign bus.out_pc    = r_q_pc[0];
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_fetch_cnt, r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else if (w_start) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_pop && (r_fetch_cnt != '1)) r_fetch_cnt <= r_fetch_cnt + 16'd1;
      if (bus.out_valid && !bus.out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.fetch_cnt = r_fetch_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.fetch_cnt = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule
